// File: rtl/unit_stuff.sv
// unit_stuff -- isochronous slot generator.
//
// Buffers a data stream in a small FIFO and emits exactly one token per
// slot on dout: a data token {1'b0, payload} when buffered data exists at
// load time, otherwise a Unit gap filler {1'b1, zeros}.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid && ready are both high; the producer holds valid and data
// stable until that edge; ready never depends on the same-cycle valid of
// the other side.
//
// Optional build feature: define UNIT_STUFF_STATS_EN to add the 16-bit
// saturating unit_cnt output that counts Unit tokens handshaked on dout.
// Without the macro there is no port and no counter logic.
module unit_stuff #(
  parameter int W      = 8,
  parameter int PERIOD = 1,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [W-1:0] din_data,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [W:0]   dout_data
`ifdef UNIT_STUFF_STATS_EN
  ,
  output logic [15:0]  unit_cnt
`endif
);

  // Parameter sanity checks, evaluated at elaboration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("unit_stuff: DEPTH must be a power of two >= 2");
  end
  if (PERIOD < 1 || PERIOD > 65535) begin : g_period_chk
    $error("unit_stuff: PERIOD must be in 1..65535");
  end
  if ($bits(dout_data) != $bits(din_data) + 1) begin : g_width_chk
    $error("unit_stuff: dout width must be din width + 1");
  end

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [15:0] RELOAD     = 16'(PERIOD - 1);
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [W:0]  UNIT_TOKEN = {1'b1, {W{1'b0}}};

  // FIFO storage and pointers; the extra MSB separates full from empty.
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  // Slot machinery and the output token register.
  logic [15:0]  cnt;
  logic         load;
  logic         ovalid;
  logic [W:0]   odata;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // din_ready looks only at registered fullness, so a same-cycle pop
  // never opens the input for a full FIFO.
  assign din_ready = !full;
  assign push      = din_valid && !full;

  // A slot opens when the countdown has expired and the output register
  // is free or being drained this edge.
  assign load = (cnt == 16'd0) && (!ovalid || dout_ready);
  assign pop  = load && !empty;

  assign dout_valid = ovalid;
  assign dout_data  = odata;

  // FIFO write port; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= din_data;
    end
  end

  // FIFO pointer update; push and pop may happen on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Slot counter and output token: load data or Unit, else drain/countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= 16'd0;
      ovalid <= 1'b0;
      odata  <= '0;
    end else if (load) begin
      ovalid <= 1'b1;
      cnt    <= RELOAD;
      if (!empty) begin
        odata <= {1'b0, mem[rptr[AW-1:0]]};
      end else begin
        odata <= UNIT_TOKEN;
      end
    end else begin
      // Missed slots are not banked: the counter simply rests at zero
      // while backpressure holds the current token.
      if (cnt != 16'd0) begin
        cnt <= cnt - 16'd1;
      end
      if (ovalid && dout_ready) begin
        ovalid <= 1'b0;
      end
    end
  end

`ifdef UNIT_STUFF_STATS_EN
  // Saturating count of Unit tokens accepted by the downstream side.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unit_cnt <= 16'd0;
    end else if (ovalid && dout_ready && odata[W] && (unit_cnt != 16'hFFFF)) begin
      unit_cnt <= unit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unit_stuff.sv
// tb_unit_stuff -- bench for unit_stuff.
// Three instances (PERIOD 1, 3, 4) share one stimulus stream. A slot-level
// model (queues and integer countdowns) predicts every output each cycle,
// a scoreboard checks data order end to end, and directed steps pin the
// hand-derived values of the reset, latency, hold and full scenarios.
// unit_cnt is checked when UNIT_STUFF_STATS_EN is defined.
module tb_unit_stuff;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int NI    = 3;

  function automatic int per_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  // Clock / reset block.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         din_valid  = 1'b0;
  logic [W-1:0] din_data   = '0;
  logic         dout_ready = 1'b0;
  logic         din_ready  [NI];
  logic         dout_valid [NI];
  logic [W:0]   dout_data  [NI];
`ifdef UNIT_STUFF_STATS_EN
  logic [15:0]  unit_cnt   [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    unit_stuff #(
      .W      (W),
      .PERIOD (per_of(g)),
      .DEPTH  (DEPTH)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din_ready  (din_ready[g]),
      .din_data   (din_data),
      .dout_valid (dout_valid[g]),
      .dout_ready (dout_ready),
      .dout_data  (dout_data[g])
`ifdef UNIT_STUFF_STATS_EN
      ,
      .unit_cnt   (unit_cnt[g])
`endif
    );
  end

  // Counters.
  int n_pass  = 0;
  int n_total = 0;

  // Slot-level reference model and end-to-end scoreboard.
  logic [W-1:0] fq    [NI][$];
  logic [W-1:0] exp_q [NI][$];
  bit           m_ovalid [NI];
  logic [W:0]   m_odata  [NI];
  int           m_cnt    [NI];
  int           m_ucnt   [NI];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      fq[i].delete();
      exp_q[i].delete();
      m_ovalid[i] = 1'b0;
      m_odata[i]  = '0;
      m_cnt[i]    = 0;
      m_ucnt[i]   = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs about to be seen.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      bit           was_full;
      bit           hs;
      logic [W-1:0] head;
      was_full = (fq[i].size() == DEPTH);
      hs       = m_ovalid[i] && dout_ready;
      if (hs && m_odata[i][W] && m_ucnt[i] < 65535) m_ucnt[i]++;
      if (m_cnt[i] == 0 && (!m_ovalid[i] || dout_ready)) begin
        if (fq[i].size() > 0) begin
          head = fq[i].pop_front();
          m_odata[i] = {1'b0, head};
        end else begin
          m_odata[i] = {1'b1, {W{1'b0}}};
        end
        m_ovalid[i] = 1'b1;
        m_cnt[i]    = per_of(i) - 1;
      end else begin
        if (m_cnt[i] > 0) m_cnt[i]--;
        if (hs) m_ovalid[i] = 1'b0;
      end
      if (din_valid && !was_full) fq[i].push_back(din_data);
    end
  endtask

  // Scoreboard: data tokens leaving must match accepted inputs in order.
  task automatic sb_step();
    for (int i = 0; i < NI; i++) begin
      if (dout_valid[i] && dout_ready && dout_data[i][W] == 1'b0) begin
        chk($sformatf("sb_has_word[%0d]", i), 32'(exp_q[i].size() > 0), 32'd1);
        if (exp_q[i].size() > 0) begin
          chk($sformatf("sb_data[%0d]", i), 32'(dout_data[i][W-1:0]), 32'(exp_q[i].pop_front()));
        end
      end
      if (din_valid && din_ready[i]) exp_q[i].push_back(din_data);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("dout_valid[%0d]", i), 32'(dout_valid[i]), 32'(m_ovalid[i]));
      chk($sformatf("dout_data[%0d]", i), 32'(dout_data[i]), 32'(m_odata[i]));
      chk($sformatf("din_ready[%0d]", i), 32'(din_ready[i]), 32'(fq[i].size() < DEPTH));
`ifdef UNIT_STUFF_STATS_EN
      chk($sformatf("unit_cnt[%0d]", i), 32'(unit_cnt[i]), 32'(m_ucnt[i]));
`endif
    end
  endtask

  // Driver: one rising edge, then compare just after it.
  task automatic tick();
    sb_step();
    if (rst) model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  int acc;
  int dcount;

  initial begin
    // Power-on reset.
    #2 rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_valid[%0d]", i), 32'(dout_valid[i]), 32'd0);
      chk($sformatf("rst_data[%0d]", i), 32'(dout_data[i]), 32'd0);
      chk($sformatf("rst_ready[%0d]", i), 32'(din_ready[i]), 32'd1);
    end
    tick();
    tick();
    rst = 1'b1;
    dout_ready = 1'b1;

    // Idle input: Unit appears one edge after release, then every cycle for PERIOD=1.
    tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("first_unit[%0d]", i), 32'(dout_data[i]), 32'h100);
      chk($sformatf("first_valid[%0d]", i), 32'(dout_valid[i]), 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("p1_unit_stream", 32'(dout_data[0]), 32'h100);
    end
`ifdef UNIT_STUFF_STATS_EN
    chk("unit_cnt_10", 32'(unit_cnt[0]), 32'd10);
`endif

    // Three back-to-back words: each shows on dout one edge after its push.
    din_valid = 1'b1;
    din_data  = 8'h11;
    tick();
    chk("seq_unit_before", 32'(dout_data[0]), 32'h100);
    din_data = 8'h22;
    tick();
    chk("seq_11", 32'(dout_data[0]), 32'h011);
    din_data = 8'h33;
    tick();
    chk("seq_22", 32'(dout_data[0]), 32'h022);
    din_valid = 1'b0;
    tick();
    chk("seq_33", 32'(dout_data[0]), 32'h033);
    tick();
    chk("seq_unit_after", 32'(dout_data[0]), 32'h100);
    for (int k = 0; k < 15; k++) tick();

    // Constant traffic: PERIOD=4 instance delivers one data token per 4 cycles.
    din_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din_data = 8'($urandom);
      tick();
    end
    dcount = 0;
    for (int k = 0; k < 16; k++) begin
      din_data = 8'($urandom);
      if (dout_valid[2] && dout_ready && !dout_data[2][W]) dcount++;
      tick();
    end
    chk("p4_cadence", 32'(dcount), 32'd4);
    din_valid = 1'b0;
    for (int k = 0; k < 30; k++) tick();

    // Hold 0x5A under backpressure; DEPTH+1 words fit before din_ready falls.
    acc = 0;
    din_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      din_data = 8'(8'h5A + acc);
      if (din_ready[0]) acc++;
      tick();
    end
    chk("hold_loaded", 32'(dout_data[0]), 32'h05A);
    dout_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      din_data = 8'(8'h5A + acc);
      if (din_ready[0]) acc++;
      tick();
      chk("hold_data", 32'(dout_data[0]), 32'h05A);
      chk("hold_valid", 32'(dout_valid[0]), 32'd1);
    end
    chk("held_words", 32'(acc), 32'(DEPTH + 1));
    chk("full_ready_low", 32'(din_ready[0]), 32'd0);
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    tick();
    chk("after_hold_next", 32'(dout_data[0]), 32'h05B);
    for (int k = 0; k < 30; k++) tick();

    // Mid-stream reset with full FIFOs: everything is discarded.
    dout_ready = 1'b0;
    din_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      din_data = 8'($urandom);
      tick();
    end
    din_valid = 1'b0;
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("midrst_valid[%0d]", i), 32'(dout_valid[i]), 32'd0);
      chk($sformatf("midrst_ready[%0d]", i), 32'(din_ready[i]), 32'd1);
    end
    model_reset();
    tick();
    rst = 1'b1;
    dout_ready = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("post_rst_unit[%0d]", i), 32'(dout_data[i]), 32'h100);
    end
    for (int k = 0; k < 5; k++) tick();

    // Random valid/ready traffic.
    for (int k = 0; k < 400; k++) begin
      din_valid  = 1'($urandom_range(0, 1));
      din_data   = 8'($urandom);
      dout_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Drain and confirm nothing was lost.
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("drained[%0d]", i), 32'(exp_q[i].size()), 32'd0);
    end

    // Final report.
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/unit_stuff.md
# unit_stuff

Isochronous slot generator: buffers a `data_type` stream and emits one `data_type | Unit` token per slot on its output. A slot carries data when buffered data is available and carries Unit (the gap filler) otherwise. It is the producer-side counterpart of the valve that strips Unit tokens. It sits where a bursty producer must feed a fixed-cadence union channel.

## Interface
Parameters:
- `PERIOD`, 1: minimum cycles between successive slot loads; legal range 1..65535.
- `DEPTH`, 4: input FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `din`  dti.consumer  W: `data_type`.
- `dout`  dti.producer  W+1: `data_type | Unit`.
  - Bit W is ctrl: 0 means data, 1 means Unit.
  - Bits W-1:0 are the payload.
  - Elaboration error if `$size(dout.data) != $size(din.data)+1`.
- `unit_cnt`  out  16: only with `UNIT_STUFF_STATS_EN`; see Configuration.

## Operation
- Input FIFO, `DEPTH` entries.
  - `din.ready = !full`, combinational, independent of same-cycle pop.
  - Push on `din.valid && din.ready`.
- Output register (`ovalid`, `odata`) drives `dout` directly.
  - `dout.valid = ovalid`.
  - Token is held stable until `dout.valid && dout.ready`.
- Slot counter `cnt`, range 0..PERIOD-1.
  - Decrements each cycle while nonzero, saturating at 0.
  - Counts regardless of backpressure.
- Load condition: `cnt==0 && (!ovalid || dout.ready)`. On load:
  - FIFO non-empty (as registered before this edge): pop head, `odata = {1'b0, head}`.
  - FIFO empty: `odata = {1'b1, W'b0}` (Unit; payload zeros).
  - `ovalid = 1`, `cnt = PERIOD-1`.
- When not loading, if `dout.valid && dout.ready`, `ovalid = 0`.
- Data order is preserved.
- Data is never dropped or duplicated.
- Unit is never produced while the FIFO holds data at load time.

## Timing
- Reset values:
  - `ovalid=0`, `odata=0`, `cnt=0`, FIFO empty.
  - `din.ready=1`, `unit_cnt=0`.
  - Reset assertion clears all state asynchronously.
  - Mid-operation reset discards FIFO contents and any held token.
- First load occurs at the first rising edge after reset release.
  - If `din` is idle, `dout.valid=1` carrying Unit one edge after release.
- Latency: word pushed at edge k into an empty FIFO loads at edge k+1 at the earliest; `dout` shows it after k+1. No bypass path.
- `PERIOD=1` with `dout.ready=1`: one token every cycle.
- `PERIOD=N`: loads are at least N edges apart.
  - Backpressure delays a load but does not accumulate missed slots; at most one token is pending.
- Full FIFO with a same-cycle pop: `din.ready` is still 0 that cycle.
- Simultaneous push and pop on a non-full FIFO: both occur, occupancy unchanged.
- Pointers wrap modulo `DEPTH`. An extra pointer bit distinguishes full from empty.

## Configuration
- `UNIT_STUFF_STATS_EN` defined:
  - Adds port `unit_cnt`, which increments when a Unit token handshakes on `dout`.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Not defined: no port and no counter logic; behaviour otherwise identical.

## Test plan
- Reset release, `din` idle, `PERIOD=1`, `dout.ready=1`:
  - `dout` emits Unit (`ctrl=1`, payload 0) every cycle from edge 1.
  - `unit_cnt` reaches 10 after 10 cycles.
- `PERIOD=1`, push 0x11, 0x22, 0x33 back-to-back, `dout.ready=1`:
  - Data tokens 0x11, 0x22, 0x33 with `ctrl=0`, in order, first at edge k+1.
  - Units before and after.
- `PERIOD=4`, constant `din` traffic, `dout.ready=1`:
  - One data token every 4 cycles.
  - `din.ready` falls after `DEPTH`+1 words are held (FIFO plus output register).
- `dout.ready=0` for 8 cycles while a data token 0x5A is held:
  - `dout.data`/`dout.valid` stable throughout.
  - After ready returns, 0x5A handshakes once, followed by the next FIFO word, not a Unit.
- Fill FIFO (`DEPTH`=4), assert `rst` low mid-stream, release:
  - `dout.valid` drops immediately and `din.ready=1`.
  - First post-reset token is Unit; no pre-reset data appears.
- Random valid/ready, `PERIOD` ∈ {1,3}:
  - The data-token sequence equals the input sequence.
  - No Unit is loaded while the FIFO is non-empty.
